// File: rtl/hex_scan.sv
// hex_scan: time-multiplexed digit scanner that feeds a hex-to-seven-segment
// decoder. A packed multi-digit value is accepted over valid/ready into a
// single pending buffer. The buffer is copied to the displayed (shadow) copy
// only at a frame boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   load_valid   load_data is valid this cycle
//   load_ready   pending buffer empty; transfer on load_valid && load_ready
//   load_data    packed value, digit i = load_data[4i+3:4i], digit 0 = LSD
//   blank_lz     leading-zero blanking enable, sampled at every slot change
//   nibble       nibble of the active digit (decoder input)
//   digit_en     one-hot active-low digit select
//   blank        active digit must be dark
//   frame_start  one-cycle pulse when digit 0 becomes active after a wrap
module hex_scan #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned DIV    = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [PW-1:0]     PRE_LAST  = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_FIRST  = ~(DIGITS'(1));

  logic [4*DIGITS-1:0] pending;
  logic                pend_full;
  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;

  logic                slot_wrap;
  logic                frame_wrap;
  logic                xfer;
  logic [IW-1:0]       idx_nx;
  logic [4*DIGITS-1:0] shadow_nx;
  logic [DIGITS-1:0]   zero_from;
  logic [3:0]          nibble_nx;
  logic [DIGITS-1:0]   en_nx;
  logic                blank_nx;

  assign load_ready = !pend_full;

  always_comb begin
    slot_wrap  = (presc == PRE_LAST);
    frame_wrap = slot_wrap && (idx == IDX_LAST);
    xfer       = load_valid && !pend_full;
    idx_nx     = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    shadow_nx  = (frame_wrap && pend_full) ? pending : shadow;
  end

  // zero_from[i]: digits i..DIGITS-1 of the shadow that is current after
  // this edge are all zero. Using shadow_nx lets blanking at a frame
  // boundary follow the newly committed value.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (shadow_nx[4*DIGITS-1 -: 4] == 4'h0);
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_from[i-1] = zero_from[i] && (shadow_nx[4*(i-1) +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble_nx = '0;
    en_nx     = '1;
    blank_nx  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_nx == IW'(i)) begin
        nibble_nx = shadow_nx[4*i +: 4];
        en_nx[i]  = 1'b0;
        blank_nx  = blank_lz && (i != 0) && zero_from[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      pend_full   <= 1'b0;
      shadow      <= '0;
      presc       <= '0;
      idx         <= '0;
      nibble      <= '0;
      digit_en    <= EN_FIRST;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      presc       <= slot_wrap ? '0 : presc + PW'(1);
      shadow      <= shadow_nx;
      // A transfer needs an empty buffer and the boundary only drains a
      // full one, so the two branches are mutually exclusive.
      if (xfer) begin
        pending   <= load_data;
        pend_full <= 1'b1;
      end else if (frame_wrap && pend_full) begin
        pend_full <= 1'b0;
      end
      if (slot_wrap) begin
        idx      <= idx_nx;
        nibble   <= nibble_nx;
        digit_en <= en_nx;
        blank    <= blank_nx;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan.sv
// Bench for hex_scan: instance A (DIGITS=6, DIV=4) runs the directed
// scenarios, instance B (DIGITS=2, DIV=1) runs continuous loads alongside.
// A cycle-count model predicts every output on every falling edge.
module tb_hex_scan;

  logic        clk;
  logic        reset_n;
  logic        released;
  logic        chk_on;

  logic        va, rdy_a, blz, blank_a, fs_a;
  logic [23:0] da;
  logic [3:0]  nib_a;
  logic [5:0]  en_a;

  logic        vb, rdy_b, blank_b, fs_b;
  logic [7:0]  db;
  logic [3:0]  nib_b;
  logic [1:0]  en_b;

  int n_checks = 0;
  int n_fail   = 0;

  hex_scan #(.DIGITS(6), .DIV(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .load_valid(va), .load_ready(rdy_a),
    .load_data(da), .blank_lz(blz), .nibble(nib_a), .digit_en(en_a),
    .blank(blank_a), .frame_start(fs_a)
  );

  hex_scan #(.DIGITS(2), .DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .load_valid(vb), .load_ready(rdy_b),
    .load_data(db), .blank_lz(blz), .nibble(nib_b), .digit_en(en_b),
    .blank(blank_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // c = rising edges since reset release. Digit shown = (c/DIV) mod DIGITS,
  // frame boundary when c is a multiple of DIGITS*DIV.
  int          c      = 0;
  logic [23:0] pend_a = '0, sh_a = '0;
  logic        full_a = 1'b0, blz_a = 1'b0;
  logic [7:0]  pend_b = '0, sh_b = '0;
  logic        full_b = 1'b0, blz_b = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c = 0;
      pend_a = '0; sh_a = '0; full_a = 1'b0; blz_a = 1'b0;
      pend_b = '0; sh_b = '0; full_b = 1'b0; blz_b = 1'b0;
    end else begin
      c = c + 1;
      if (va && !full_a) begin
        pend_a = da; full_a = 1'b1;
      end else if (c % 24 == 0 && full_a) begin
        sh_a = pend_a; full_a = 1'b0;
      end
      if (c % 4 == 0) blz_a = blz;
      if (vb && !full_b) begin
        pend_b = db; full_b = 1'b1;
      end else if (c % 2 == 0 && full_b) begin
        sh_b = pend_b; full_b = 1'b0;
      end
      blz_b = blz;
    end
  end

  function automatic logic [31:0] nib_of(input logic [31:0] v, input int d);
    return (v >> (4 * d)) & 32'hF;
  endfunction

  function automatic logic [31:0] blank_of(input logic [31:0] v, input int d,
                                           input logic lz);
    return 32'(lz && d != 0 && ((v >> (4 * d)) == 32'd0));
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (c=%0d, t=%0t)",
               name, got, exp, c, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int   acc_b   = 0;
  logic prev_rb = 1'b1;

  always @(negedge clk) begin
    int d;
    if (chk_on) begin
      d = (c / 4) % 6;
      check("a_nibble",  32'(nib_a),   nib_of(32'(sh_a), d));
      check("a_digit_en", 32'(en_a),   32'h3F & ~(32'd1 << d));
      check("a_blank",   32'(blank_a), blank_of(32'(sh_a), d, blz_a));
      check("a_frame",   32'(fs_a),    32'(c > 0 && c % 24 == 0));
      check("a_ready",   32'(rdy_a),   32'(!full_a));
      d = c % 2;
      check("b_nibble",  32'(nib_b),   nib_of(32'(sh_b), d));
      check("b_digit_en", 32'(en_b),   32'h3 & ~(32'd1 << d));
      check("b_blank",   32'(blank_b), blank_of(32'(sh_b), d, blz_b));
      check("b_frame",   32'(fs_b),    32'(c > 0 && c % 2 == 0));
      check("b_ready",   32'(rdy_b),   32'(!full_b));
      // ready only falls on an accepted transfer; exactly one per frame
      // while load_valid is held high
      if (!reset_n) begin
        acc_b   = 0;
        prev_rb = 1'b1;
      end else begin
        if (prev_rb && !rdy_b) acc_b++;
        prev_rb = rdy_b;
        if (fs_b) begin
          check("b_accepts_per_frame", 32'(acc_b), 32'd1);
          acc_b = 0;
        end
      end
    end
  end

  // ---------------- B driver: continuous, incrementing loads ----------------
  initial begin
    vb = 1'b0;
    db = 8'h0F;
    wait (released);
    vb = 1'b1;
    db = 8'h10;
    forever begin
      @(negedge clk);
      db = db + 8'h1;
    end
  end

  task automatic wait_c(input int target);
    int guard = 0;
    while (c < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (c < target) check("wait_bound", 32'(c), 32'(target));
  endtask

  // ---------------- A scenarios ----------------
  initial begin
    released = 1'b0;
    chk_on   = 1'b0;
    reset_n  = 1'b1;
    va = 1'b0; da = '0; blz = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    check("in_reset_en", 32'(en_a), 32'h3E);
    check("in_reset_ready", 32'(rdy_a), 32'd1);
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    released = 1'b1;
    check("rst_nibble", 32'(nib_a), 32'd0);
    check("rst_en", 32'(en_a), 32'h3E);
    check("rst_blank", 32'(blank_a), 32'd0);
    check("rst_frame", 32'(fs_a), 32'd0);
    check("rst_ready", 32'(rdy_a), 32'd1);

    // idle scan + DIV=1 instance
    wait_c(2);
    check("b_c2_nib", 32'(nib_b), 32'h0);
    check("b_c2_en", 32'(en_b), 32'h2);
    check("b_c2_frame", 32'(fs_b), 32'd1);
    wait_c(3);
    check("b_c3_nib", 32'(nib_b), 32'h1);
    check("b_c3_en", 32'(en_b), 32'h1);
    check("b_c3_frame", 32'(fs_b), 32'd0);
    wait_c(4);
    check("a_c4_en", 32'(en_a), 32'h3D);
    check("b_c4_nib", 32'(nib_b), 32'h2);
    wait_c(5);
    check("b_c5_nib", 32'(nib_b), 32'h1);
    wait_c(23);
    check("a_c23_en", 32'(en_a), 32'h1F);
    check("a_c23_frame", 32'(fs_a), 32'd0);
    wait_c(24);
    check("a_c24_frame", 32'(fs_a), 32'd1);
    check("a_c24_en", 32'(en_a), 32'h3E);
    wait_c(25);
    check("a_c25_frame", 32'(fs_a), 32'd0);
    wait_c(48);
    check("a_c48_frame", 32'(fs_a), 32'd1);

    // load mid-frame
    wait_c(52);
    va = 1'b1; da = 24'h12AB3F;
    wait_c(53);
    va = 1'b0;
    check("ld_ready_drop", 32'(rdy_a), 32'd0);
    wait_c(60);
    check("ld_cur_frame", 32'(nib_a), 32'h0);
    wait_c(71);
    check("ld_ready_pre", 32'(rdy_a), 32'd0);
    check("ld_last_old", 32'(nib_a), 32'h0);
    wait_c(72);
    check("ld_ready_back", 32'(rdy_a), 32'd1);
    check("ld_d0", 32'(nib_a), 32'hF);
    check("ld_frame", 32'(fs_a), 32'd1);
    wait_c(76); check("ld_d1", 32'(nib_a), 32'h3);
    wait_c(80); check("ld_d2", 32'(nib_a), 32'hB);
    wait_c(84); check("ld_d3", 32'(nib_a), 32'hA);
    wait_c(88); check("ld_d4", 32'(nib_a), 32'h2);
    wait_c(92); check("ld_d5", 32'(nib_a), 32'h1);

    // back-pressure
    wait_c(100);
    va = 1'b1; da = 24'h111111;
    wait_c(101);
    da = 24'h222222;
    check("bp_ready0", 32'(rdy_a), 32'd0);
    wait_c(110);
    check("bp_held", 32'(rdy_a), 32'd0);
    wait_c(120);
    check("bp_ready1", 32'(rdy_a), 32'd1);
    check("bp_first", 32'(nib_a), 32'h1);
    wait_c(121);
    va = 1'b0;
    check("bp_accept2", 32'(rdy_a), 32'd0);
    wait_c(143);
    check("bp_first_last", 32'(nib_a), 32'h1);
    wait_c(144);
    check("bp_second", 32'(nib_a), 32'h2);

    // leading-zero blanking
    wait_c(150);
    blz = 1'b1; va = 1'b1; da = 24'h000A05;
    wait_c(151);
    va = 1'b0;
    wait_c(168); check("lz_d0_nib", 32'(nib_a), 32'h5);
                 check("lz_d0_blank", 32'(blank_a), 32'd0);
    wait_c(172); check("lz_d1_nib", 32'(nib_a), 32'h0);
                 check("lz_d1_blank", 32'(blank_a), 32'd0);
    wait_c(176); check("lz_d2_nib", 32'(nib_a), 32'hA);
                 check("lz_d2_blank", 32'(blank_a), 32'd0);
    wait_c(180); check("lz_d3_blank", 32'(blank_a), 32'd1);
                 check("lz_d3_nib", 32'(nib_a), 32'h0);
    wait_c(184); check("lz_d4_blank", 32'(blank_a), 32'd1);
    wait_c(188); check("lz_d5_blank", 32'(blank_a), 32'd1);
    wait_c(190);
    blz = 1'b0;
    wait_c(191); check("lz_hold_slot", 32'(blank_a), 32'd1);
    wait_c(204); check("lz_off_blank", 32'(blank_a), 32'd0);
                 check("lz_off_en", 32'(en_a), 32'h37);

    // reset mid-operation with a pending value
    wait_c(220);
    va = 1'b1; da = 24'h777777;
    wait_c(221);
    va = 1'b0;
    check("mr_pending", 32'(rdy_a), 32'd0);
    wait_c(229);
    check("mr_digit3", 32'(en_a), 32'h37);
    #2 reset_n = 1'b0;
    #1;
    check("mr_en", 32'(en_a), 32'h3E);
    check("mr_nibble", 32'(nib_a), 32'h0);
    check("mr_blank", 32'(blank_a), 32'd0);
    check("mr_frame", 32'(fs_a), 32'd0);
    check("mr_ready", 32'(rdy_a), 32'd1);
    check("mr_b_en", 32'(en_b), 32'h2);
    check("mr_b_ready", 32'(rdy_b), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_c(1);
    check("mr_rel_en", 32'(en_a), 32'h3E);
    check("mr_rel_ready", 32'(rdy_a), 32'd1);
    wait_c(4);
    check("mr_rel_step", 32'(en_a), 32'h3D);
    wait_c(24);
    check("mr_rel_frame", 32'(fs_a), 32'd1);
    check("mr_discarded", 32'(nib_a), 32'h0);
    wait_c(30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at %0t, expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
